// File: rtl/dff_reg.sv
// Cascaded D-type register: DEPTH stages of WIDTH bits, synchronous active-low reset.
// The default parameters give a plain 1-bit D flip-flop.
module dff_reg #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  // Each stage owns its register, so every flop has exactly one driver.
  // Reset reloads all stages on the same edge, which flushes any data in flight.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_reg;

    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (!reset) begin
          stage_reg <= RESET_VALUE;
        end else begin
          stage_reg <= data;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (!reset) begin
          stage_reg <= RESET_VALUE;
        end else begin
          stage_reg <= g_stage[gi-1].stage_reg;
        end
      end
    end
  end

  assign q = g_stage[DEPTH-1].stage_reg;

endmodule

// File: tb/tb_dff_reg.sv
// Directed bench for dff_reg: a default 1-bit instance and an 8-bit, 3-deep instance
// with reset value 8'hA5, driven from tables of hand-computed vectors.
module tb_dff_reg;

  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset1 = 1'b1;
  logic       data1 = 1'b0;
  logic       q1;
  logic       reset8 = 1'b0;
  logic [7:0] data8 = 8'h00;
  logic [7:0] q8;

  int total_cnt = 0;
  int pass_cnt  = 0;

  vec_t tab1[15];
  vec_t tab8[10];

  // Rising edges at t = 100, 300, 500, ...
  always #100 clk = ~clk;

  dff_reg u_dut1 (
    .clk   (clk),
    .reset (reset1),
    .data  (data1),
    .q     (q1)
  );

  dff_reg #(
    .WIDTH       (8),
    .DEPTH       (3),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clk   (clk),
    .reset (reset8),
    .data  (data8),
    .q     (q8)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] edge_q;

    // 1-bit: basic capture, stream sequence, then a one-edge reset pulse with data=1.
    tab1[0]  = '{1'b1, 8'h00, 8'h00};  // edge 100
    tab1[1]  = '{1'b1, 8'h01, 8'h01};  // edge 300
    tab1[2]  = '{1'b1, 8'h01, 8'h01};
    tab1[3]  = '{1'b1, 8'h01, 8'h01};
    tab1[4]  = '{1'b1, 8'h01, 8'h01};
    tab1[5]  = '{1'b1, 8'h01, 8'h01};
    tab1[6]  = '{1'b1, 8'h01, 8'h01};  // edge 1300
    tab1[7]  = '{1'b1, 8'h00, 8'h00};  // edge 1500
    tab1[8]  = '{1'b1, 8'h00, 8'h00};
    tab1[9]  = '{1'b1, 8'h01, 8'h01};  // edge 1900
    tab1[10] = '{1'b1, 8'h00, 8'h00};  // edge 2100
    tab1[11] = '{1'b1, 8'h01, 8'h01};
    tab1[12] = '{1'b0, 8'h01, 8'h00};  // reset wins over data=1
    tab1[13] = '{1'b1, 8'h01, 8'h01};
    tab1[14] = '{1'b1, 8'h01, 8'h01};

    // 8-bit, 3 deep: reset, stream 01..04, mid-stream reset, restart.
    tab8[0] = '{1'b0, 8'hFF, 8'hA5};
    tab8[1] = '{1'b0, 8'hFF, 8'hA5};
    tab8[2] = '{1'b1, 8'h01, 8'hA5};
    tab8[3] = '{1'b1, 8'h02, 8'hA5};
    tab8[4] = '{1'b1, 8'h03, 8'h01};
    tab8[5] = '{1'b1, 8'h04, 8'h02};
    tab8[6] = '{1'b0, 8'h05, 8'hA5};
    tab8[7] = '{1'b1, 8'h06, 8'hA5};
    tab8[8] = '{1'b1, 8'h07, 8'hA5};
    tab8[9] = '{1'b1, 8'h08, 8'h06};

    // Inputs change at falling edges (mid-cycle); q is read at and 1 unit after each rising edge.
    for (int k = 0; k < 15; k++) begin
      reset1 = tab1[k].rst;
      data1  = tab1[k].d[0];
      @(posedge clk);
      edge_q = {7'b0, q1};
      #1;
      check($sformatf("w1_vec%0d", k), {7'b0, q1}, tab1[k].exp);
      if (k > 0) begin
        check($sformatf("w1_edge_sample%0d", k), edge_q, tab1[k-1].exp);
      end
      $display("w1 vec %0d: reset=%b data=%b q=%b exp=%b at_edge=%b", k, tab1[k].rst,
               tab1[k].d[0], q1, tab1[k].exp[0], edge_q[0]);
      @(negedge clk);
    end

    // Reset pulse entirely between edges must not clear q.
    reset1 = 1'b1;
    data1  = 1'b1;
    @(posedge clk);
    #20 reset1 = 1'b0;
    #10 check("async_during_pulse", {7'b0, q1}, 8'h01);
    #130 reset1 = 1'b1;
    #10 check("async_after_pulse", {7'b0, q1}, 8'h01);
    @(posedge clk);
    #1 check("async_next_edge", {7'b0, q1}, 8'h01);
    $display("w1 async pulse: q=%b", q1);
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      reset8 = tab8[k].rst;
      data8  = tab8[k].d;
      @(posedge clk);
      #1;
      check($sformatf("w8_vec%0d", k), q8, tab8[k].exp);
      $display("w8 vec %0d: reset=%b data=%h q=%h exp=%h", k, tab8[k].rst, tab8[k].d, q8,
               tab8[k].exp);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
